// File: rtl/rb_fifo_gen.sv
// -----------------------------------------------------------------------------
// rb_fifo_gen
//   Single-clock ring-buffer FIFO with configurable width and power-of-two
//   depth. It accepts push and pop in the same cycle and exposes an occupancy
//   count, registered full/empty/almost flags and a synchronous flush.
//   data_out is first-word-fall-through: it is read combinationally from
//   storage at the read pointer.
//
// Parameters
//   DATA_W    data word width in bits
//   ADDR_W    log2 of depth; DEPTH = 2**ADDR_W
//   AF_LEVEL  almost_full  asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clock         sole clock, rising edge
//   rst           asynchronous active-low reset. Assertion takes effect
//                 immediately; release is synchronised to clock internally.
//   flush         synchronous clear of pointers, count and flags (active-high)
//   push/data_in  write request and write data
//   pop           read request
//   data_out      head word; valid whenever empty == 0
//   full, empty, almost_full, almost_empty   registered status flags
//   count         occupancy, 0..DEPTH
//   overflow      sticky: push attempted while full
//   underflow     sticky: pop attempted while empty
//
// Build option
//   RBFIFO_ERR_EN  when defined, overflow/underflow are sticky error
//                  registers. When undefined, both outputs are tied to 0
//                  and no error registers exist. The port list is the same
//                  in both builds.
// -----------------------------------------------------------------------------
module rb_fifo_gen #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Compare constants are sized to the count width so that every comparison
  // is a same-width unsigned compare.
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AF    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] CNT_AE    = (ADDR_W + 1)'(AE_LEVEL);

  // ---------------------------------------------------------------------------
  // Reset conditioning: assert asynchronously, release on a clock edge.
  // When rst falls, both stages clear at once, so every register below also
  // resets immediately. When rst rises, the internal reset is released two
  // edges later. This keeps release from landing close to an active edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n_int;

  // NOTE: every clocked process uses non-blocking (<=) assignments, so all
  // registers sample their pre-edge values and simulation ordering cannot
  // change the result.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync[1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;

  logic              push_ok;
  logic              pop_ok;
  logic [ADDR_W:0]   wr_ptr_nxt;
  logic [ADDR_W:0]   rd_ptr_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              full_nxt;
  logic              empty_nxt;
  logic              almost_full_nxt;
  logic              almost_empty_nxt;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // Acceptance uses only the registered flags. A pop does not free a slot for
  // a push in the same cycle, and a push does not feed a pop on an empty FIFO.
  // Pointers carry one extra wrap bit and simply roll over modulo 2*DEPTH.
  // ---------------------------------------------------------------------------
  // NOTE: each signal gets a default at the top of the always_comb. That way
  // no path leaves a value unassigned, and no latch is inferred.
  always_comb begin
    push_ok    = push & ~full;
    pop_ok     = pop  & ~empty;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;

    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push_ok) wr_ptr_nxt = wr_ptr + CNT_ONE;
      if (pop_ok)  rd_ptr_nxt = rd_ptr + CNT_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end

    // The flags are derived from the next count, so they are correct in the
    // cycle right after the causing edge. A flush drives count_nxt to 0,
    // which yields the reset flag values (AF_LEVEL >= 1).
    full_nxt         = (count_nxt == CNT_DEPTH);
    empty_nxt        = (count_nxt == '0);
    almost_full_nxt  = (count_nxt >= CNT_AF);
    almost_empty_nxt = (count_nxt <= CNT_AE);
  end

  // ---------------------------------------------------------------------------
  // Pointer, count and flag registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      almost_full  <= almost_full_nxt;
      almost_empty <= almost_empty_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Its contents only matter once a
  // word has been written, and leaving out the reset lets it map onto plain
  // flops or RAM without a clear path.
  always_ff @(posedge clock) begin
    if (push_ok && !flush && rst_n_int) begin
      mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    end
  end

  // First-word-fall-through head. It is don't-care while empty.
  assign data_out = mem[rd_ptr[ADDR_W-1:0]];

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef RBFIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Flush leaves these flags alone; only reset clears them. A flush edge
  // ignores push and pop entirely, so it cannot raise an error either.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (!flush) begin
      if (push && full)  overflow_q  <= 1'b1;
      if (pop  && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_rb_fifo_gen.sv
// -----------------------------------------------------------------------------
// tb_rb_fifo_gen
//   Self-checking bench for rb_fifo_gen with default parameters (64 x 32).
//   The reference model is a queue of words plus two sticky error bits.
//   The directed scenarios are followed by randomised traffic phases.
// -----------------------------------------------------------------------------
module tb_rb_fifo_gen;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 32;
  localparam int AF_LEVEL = 28;
  localparam int AE_LEVEL = 2;

`ifdef RBFIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              rst   = 1'b0;
  logic              flush = 1'b0;
  logic              push  = 1'b0;
  logic              pop   = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              full, empty, almost_full, almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow, underflow;

  rb_fifo_gen #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .AF_LEVEL(AF_LEVEL),
    .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .flush       (flush),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Reference model
  logic [DATA_W-1:0] q [$];
  bit                m_ovf = 1'b0;
  bit                m_unf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = q.size();
    chk({tag, " count"},        64'(count),        64'(n));
    chk({tag, " empty"},        64'(empty),        64'(n == 0));
    chk({tag, " full"},         64'(full),         64'(n == DEPTH));
    chk({tag, " almost_full"},  64'(almost_full),  64'(n >= AF_LEVEL));
    chk({tag, " almost_empty"}, 64'(almost_empty), 64'(n <= AE_LEVEL));
    chk({tag, " overflow"},     64'(overflow),     64'(m_ovf));
    chk({tag, " underflow"},    64'(underflow),    64'(m_unf));
    if (n > 0) chk({tag, " data_out"}, data_out, q[0]);
  endtask

  // Drive one cycle of stimulus, apply the rules to the model at the edge,
  // then check the registered outputs 1 ns after the edge.
  task automatic step(input string tag, input bit f, input bit pu, input bit po,
                      input logic [DATA_W-1:0] d);
    int  n;
    bit  push_acc, pop_acc;
    flush   = f;
    push    = pu;
    pop     = po;
    data_in = d;
    @(posedge clock);
    n = q.size();
    if (f) begin
      q.delete();
    end else begin
      push_acc = pu && (n < DEPTH);
      pop_acc  = po && (n > 0);
      if (ERR_EN && pu && n == DEPTH) m_ovf = 1'b1;
      if (ERR_EN && po && n == 0)     m_unf = 1'b1;
      if (pop_acc)  void'(q.pop_front());
      if (push_acc) q.push_back(d);
    end
    #1;
    flush = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [DATA_W-1:0] seq;
    int pp, pq;

    // --- Reset state ---------------------------------------------------------
    repeat (3) @(posedge clock);
    #1;
    check_state("reset");
    @(negedge clock);
    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_state("reset_release");

    // --- Fill 0x1..0x20 --------------------------------------------------------
    for (int i = 1; i <= DEPTH; i++) begin
      step("fill", 1'b0, 1'b1, 1'b0, DATA_W'(i));
      chk("fill head", data_out, 64'h1);
    end
    chk("fill full", 64'(full), 64'd1);

    // --- Drain in order --------------------------------------------------------
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain head", data_out, 64'(i));
      step("drain", 1'b0, 1'b0, 1'b1, '0);
    end
    chk("drain empty", 64'(empty), 64'd1);

    // --- Fill to 16, then 100 cycles of push+pop (pointers wrap) ---------------
    seq = 64'h100;
    for (int i = 0; i < 16; i++) begin
      step("half_fill", 1'b0, 1'b1, 1'b0, seq);
      seq++;
    end
    for (int i = 0; i < 100; i++) begin
      step("stream", 1'b0, 1'b1, 1'b1, seq);
      chk("stream count", 64'(count), 64'd16);
      seq++;
    end
    while (q.size() > 0) step("stream_drain", 1'b0, 1'b0, 1'b1, '0);

    // --- Full with push+pop: only the pop is accepted --------------------------
    for (int i = 0; i < DEPTH; i++) step("refill", 1'b0, 1'b1, 1'b0, 64'h2000 + 64'(i));
    step("full_pushpop", 1'b0, 1'b1, 1'b1, 64'hDEAD);
    chk("full_pushpop count", 64'(count), 64'd31);
    chk("full_pushpop ovf", 64'(overflow), 64'(ERR_EN));

    // --- Empty with push+pop: only the push is accepted ------------------------
    while (q.size() > 0) step("empty_drain", 1'b0, 1'b0, 1'b1, '0);
    step("empty_pushpop", 1'b0, 1'b1, 1'b1, 64'hBEEF);
    chk("empty_pushpop count", 64'(count), 64'd1);
    chk("empty_pushpop head", data_out, 64'hBEEF);
    chk("empty_pushpop unf", 64'(underflow), 64'(ERR_EN));

    // --- Flush with push asserted, then a fresh push ---------------------------
    while (q.size() < 10) step("pre_flush", 1'b0, 1'b1, 1'b0, 64'h3000 + 64'(q.size()));
    step("flush", 1'b1, 1'b1, 1'b0, 64'h55);
    chk("flush count", 64'(count), 64'd0);
    step("post_flush", 1'b0, 1'b1, 1'b0, 64'hAA);
    chk("post_flush head", data_out, 64'hAA);
    chk("post_flush count", 64'(count), 64'd1);

    // --- Asynchronous reset mid-cycle ------------------------------------------
    while (q.size() < 5) step("pre_rst", 1'b0, 1'b1, 1'b0, 64'h4000 + 64'(q.size()));
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_state("async_rst");
    @(negedge clock);
    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_state("async_rst_release");

    // --- Randomised traffic: push-heavy, balanced, pop-heavy -------------------
    for (int ph = 0; ph < 3; ph++) begin
      pp = (ph == 0) ? 80 : (ph == 1) ? 50 : 20;
      pq = (ph == 0) ? 20 : (ph == 1) ? 50 : 80;
      for (int i = 0; i < 700; i++) begin
        step("random",
             $urandom_range(0, 199) == 0,
             $urandom_range(0, 99) < pp,
             $urandom_range(0, 99) < pq,
             {$urandom, $urandom});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rb_fifo_gen.md
Name: rb_fifo_gen

Overview:
Parametrised, generalised successor to the team's single-clock ring-buffer FIFO.
- Configurable data width and power-of-two depth.
- Accepts push and pop in the same cycle.
- Exposes occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Sits between producer/consumer pipeline stages sharing one clock, as a drop-in for the existing fixed 64x32 instance.

Parameters:
DATA_W, 64, data word width in bits
ADDR_W, 5, log2 of depth; DEPTH = 2**ADDR_W (default 32)
AF_LEVEL, 28, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clock  in  1  sole clock, rising edge
rst  in  1  asynchronous reset, active-low: asserts asynchronously on falling edge, releases synchronously to clock
flush  in  1  synchronous clear of pointers/flags, active-high
push  in  1  write request
data_in  in  DATA_W  write data, sampled when push accepted
pop  in  1  read request
data_out  out  DATA_W  head word (first-word-fall-through, combinational from storage)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: push attempted while full (RBFIFO_ERR_EN only)
underflow  out  1  sticky: pop attempted while empty (RBFIFO_ERR_EN only)

Behaviour:
- Storage: DEPTH x DATA_W register array; not reset; contents undefined until written.
- Pointers: wr_ptr, rd_ptr are ADDR_W+1 bits. The low ADDR_W bits address storage. The MSB is a wrap bit, so full/empty are unambiguous at wrap-around.
- Reset (rst low, asynchronous) drives:
  - wr_ptr, rd_ptr, count = 0
  - empty = 1, almost_empty = 1
  - full = 0, almost_full = 0 (AF_LEVEL >= 1)
  - overflow = 0, underflow = 0
- Acceptance, evaluated per rising edge, with the rst-high (inactive) and flush-low conditions:
  - push_ok = push & ~full
  - pop_ok = pop & ~empty
  - Flags use registered state only; no pop-frees-slot bypass and no push-to-pop bypass.
- push_ok: mem[wr_ptr[ADDR_W-1:0]] <= data_in; wr_ptr <= wr_ptr+1.
- pop_ok: rd_ptr <= rd_ptr+1.
- count update:
  - +1 on push_ok only
  - -1 on pop_ok only
  - unchanged when both or neither
- Simultaneous push and pop:
  - Not full and not empty: both accepted, count unchanged.
  - Full: only pop accepted; push dropped, overflow set if enabled.
  - Empty: only push accepted; pop dropped, underflow set if enabled.
- Flags (full, empty, almost_full, almost_empty) are registered and computed from the next count. They are valid the cycle after the causing edge, with no extra lag.
- data_out = mem[rd_ptr[ADDR_W-1:0]], zero-latency.
  - Valid whenever empty == 0.
  - Don't-care when empty.
  - Updates the cycle after pop_ok.
- flush (synchronous, priority over push/pop):
  - Pointers, count and flags go to their reset values.
  - Storage untouched; push/pop in that cycle ignored.
  - overflow/underflow NOT cleared by flush.
- Wrap-around: pointers wrap modulo 2*DEPTH with no special-casing.
- Reset mid-operation: all state returns to reset values immediately; previously stored data is lost.

Optional Feature:
RBFIFO_ERR_EN
- Defined:
  - overflow set on push & full; underflow set on pop & empty; evaluated on non-flush edges.
  - Both sticky; cleared only by rst.
  - An erroneous request never alters pointers or count.
- Not defined: overflow and underflow tied 0; no error registers synthesised; port list unchanged.

Test Plan:
- Reset release, then 32 pushes of 0x1..0x20 -> count steps 1..32; almost_full rises after push #28 (count=28); full=1 after push #32; data_out=0x1 throughout.
- From full, pop 32 times -> data_out sequence 0x1..0x20; almost_empty rises at count=2; empty=1 after the last pop; count=0.
- Fill to 16, then push+pop together for 100 cycles with incrementing data -> count stays 16, in-order data out, pointers wrap at least 3 times, no flag glitch.
- Full plus push+pop in the same cycle -> count 31, full=0, pushed word discarded, overflow=1 (ERR_EN). Empty plus push+pop in the same cycle -> count 1, data_out = pushed word, underflow=1 (ERR_EN).
- Fill to 10, assert flush one cycle with push=1 -> count=0, empty=1; next push 0xAA gives data_out=0xAA with count=1.
- Fill to 5, drop rst low mid-cycle -> count=0, empty=1 and full=0 asynchronously before the next edge; overflow/underflow=0.
